// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the FE/MEM memory-port arbiter: FSM states, owner encoding
// and the starvation counter width helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating counter of consecutive cycles the FE request has waited ungranted.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CW = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign sat = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between instruction fetch and the MEM stage,
// one transaction in flight, sequenced IDLE -> ISSUE -> WAIT -> RESP.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req_valid,
  input  logic [AW-1:0]   if_req_addr,
  output logic            if_req_ready,
  input  logic            if_flush,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rsp_data,
  input  logic            dm_req_valid,
  input  logic            dm_req_we,
  input  logic [AW-1:0]   dm_req_addr,
  input  logic [DW-1:0]   dm_req_wdata,
  input  logic [DW/8-1:0] dm_req_be,
  output logic            dm_req_ready,
  output logic            dm_rsp_valid,
  output logic [DW-1:0]   dm_rsp_data,
  output logic            mem_req_valid,
  output logic            mem_req_we,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_be,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rsp_data,
  output logic            busy,
  output logic            grant_dm
);

  localparam int unsigned BW = DW / 8;

  arb_state_t     state, state_next;
  owner_t         owner;
  logic           drop;
  logic           we_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic [BW-1:0]  be_q;
  logic [DW-1:0]  if_data_q, dm_data_q;
  logic           starve_sat, if_win, dm_win;

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk  (clk),
    .reset(reset),
    .inc  (if_req_valid && !if_win),
    .clr  (if_win || !if_req_valid),
    .sat  (starve_sat)
  );

  // DM wins by default; a starved, unflushed fetch overrides it.
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if ((state == ARB_IDLE) && !reset) begin
      if (if_req_valid && !if_flush && (starve_sat || !dm_req_valid)) begin
        if_win = 1'b1;
      end else if (dm_req_valid) begin
        dm_win = 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state;
    if_req_ready  = if_win;
    dm_req_ready  = dm_win;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_be    = '0;
    if_rsp_valid  = 1'b0;
    dm_rsp_valid  = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (if_win || dm_win) state_next = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        mem_req_valid = 1'b1;
        mem_req_we    = we_q;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        mem_req_be    = be_q;
        if (mem_req_ready) state_next = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_rsp_valid) state_next = ARB_RESP;
      end
      ARB_RESP: begin
        // A flush landing in the RESP cycle itself still suppresses the pulse.
        if_rsp_valid = (owner == OWN_IF) && !drop && !if_flush;
        dm_rsp_valid = (owner == OWN_DM);
        state_next   = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      owner     <= OWN_IF;
      drop      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      if_data_q <= '0;
      dm_data_q <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        ARB_IDLE: begin
          if (dm_win) begin
            owner   <= OWN_DM;
            we_q    <= dm_req_we;
            addr_q  <= dm_req_addr;
            wdata_q <= dm_req_wdata;
            be_q    <= dm_req_be;
          end else if (if_win) begin
            owner   <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= if_req_addr;
            wdata_q <= '0;
            be_q    <= '1;
          end
        end
        ARB_ISSUE: begin
          if (owner == OWN_IF && if_flush) drop <= 1'b1;
        end
        ARB_WAIT: begin
          if (owner == OWN_IF && if_flush) drop <= 1'b1;
          if (mem_rsp_valid) begin
            if (owner == OWN_DM) begin
              dm_data_q <= we_q ? '0 : mem_rsp_data;
            end else if (!drop && !if_flush) begin
              if_data_q <= mem_rsp_data;
            end
          end
        end
        ARB_RESP: begin
          drop <= 1'b0;
        end
      endcase
    end
  end

  assign if_rsp_data = if_data_q;
  assign dm_rsp_data = dm_data_q;
  assign busy        = (state != ARB_IDLE);
  assign grant_dm    = (owner == OWN_DM);

endmodule
